id_pipe_stage: RTL and testbench

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

---
 rtl/id_pipe_stage.sv | 193 +++++++++++++++++++
 tb/tb_id_pipe_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage.sv
// RISC-V instruction-decode stage: decode, register file and a valid/ready output register.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data into operands on accept.
module id_pipe_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            reg_file_wr_en,
    input  logic [4:0]      reg_file_wr_addr,
    input  logic [XLEN-1:0] reg_file_wr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] immediate,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [8:0]      decoded_instruction,
    output logic            alu_src,
    output logic            wb_reg_file,
    output logic            m_type_inst,
    output logic            invalid_inst
);
    localparam int         AW      = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS_U = 6'(NUM_REGS);
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    logic [XLEN-1:0] r_rf [NUM_REGS];
    logic            r_out_valid;
    logic [XLEN-1:0] r_pc, r_op1, r_op2, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [2:0]      r_func3;
    logic [6:0]      r_func7;
    logic [8:0]      r_dec;
    logic            r_alu_src, r_wb, r_m, r_inv;

    logic            w_accept, w_wr_ok;
    logic [6:0]      w_opc;
    logic [4:0]      w_rs1f, w_rs2f, w_rdf;
    logic [8:0]      w_dec, w_dec_v;
    logic [XLEN-1:0] w_imm, w_imm_v, w_op1, w_op2;
    logic            w_use_rs1, w_use_rs2, w_use_rd, w_known, w_invalid;

    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < NREGS_U);
    endfunction

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        return ((a == 5'd0) || !in_range(a)) ? '0 : r_rf[a[AW-1:0]];
    endfunction

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_wr_ok  = reg_file_wr_en && (reg_file_wr_addr != 5'd0) && in_range(reg_file_wr_addr);
    assign w_opc    = instruction_in[6:0];
    assign w_rs1f   = instruction_in[19:15];
    assign w_rs2f   = instruction_in[24:20];
    assign w_rdf    = instruction_in[11:7];

    // Opcode decode: one-hot class, which register fields are used, and the raw immediate.
    always_comb begin
        w_dec     = 9'b0;
        w_imm     = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_known   = 1'b1;
        case (w_opc)
            OPC_R:     begin w_dec[8] = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
            OPC_I:     begin w_dec[7] = 1'b1; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                             w_imm = XLEN'($signed(instruction_in[31:20])); end
            OPC_S:     begin w_dec[6] = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                             w_imm = XLEN'($signed({instruction_in[31:25], instruction_in[11:7]})); end
            OPC_LOAD:  begin w_dec[5] = 1'b1; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                             w_imm = XLEN'($signed(instruction_in[31:20])); end
            OPC_LUI:   begin w_dec[4] = 1'b1; w_use_rd = 1'b1;
                             w_imm = XLEN'($signed({instruction_in[31:12], 12'b0})); end
            OPC_B:     begin w_dec[3] = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                             w_imm = XLEN'($signed({instruction_in[31], instruction_in[7],
                                     instruction_in[30:25], instruction_in[11:8], 1'b0})); end
            OPC_JAL:   begin w_dec[2] = 1'b1; w_use_rd = 1'b1;
                             w_imm = XLEN'($signed({instruction_in[31], instruction_in[19:12],
                                     instruction_in[20], instruction_in[30:21], 1'b0})); end
            OPC_AUIPC: begin w_dec[1] = 1'b1; w_use_rd = 1'b1;
                             w_imm = XLEN'($signed({instruction_in[31:12], 12'b0})); end
            OPC_JALR:  begin w_dec[0] = 1'b1; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                             w_imm = XLEN'($signed(instruction_in[31:20])); end
            default:   w_known = 1'b0;
        endcase
    end

    // Validity qualification and operand read (RV-E register fields above the file are illegal).
    always_comb begin
        w_invalid = !w_known || (w_use_rs1 && !in_range(w_rs1f)) ||
                    (w_use_rs2 && !in_range(w_rs2f)) || (w_use_rd && !in_range(w_rdf));
        w_dec_v   = w_invalid ? 9'b0 : w_dec;
        w_imm_v   = w_invalid ? '0 : w_imm;
`ifdef REGFILE_BYPASS_EN
        w_op1     = (w_wr_ok && (reg_file_wr_addr == w_rs1f)) ? reg_file_wr_data : rf_read(w_rs1f);
        w_op2     = (w_wr_ok && (reg_file_wr_addr == w_rs2f)) ? reg_file_wr_data : rf_read(w_rs2f);
`else
        w_op1     = rf_read(w_rs1f);
        w_op2     = rf_read(w_rs2f);
`endif
    end

    // Output register: flush beats accept, accept beats hold, hold refreshes operands from writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_imm       <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_func3     <= 3'd0;
            r_func7     <= 7'd0;
            r_dec       <= 9'd0;
            r_alu_src   <= 1'b0;
            r_wb        <= 1'b0;
            r_m         <= 1'b0;
            r_inv       <= 1'b0;
        end else if (id_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= pc_in;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_imm       <= w_imm_v;
            r_rs1       <= w_rs1f;
            r_rs2       <= w_rs2f;
            r_rd        <= w_rdf;
            r_func3     <= instruction_in[14:12];
            r_func7     <= instruction_in[31:25];
            r_dec       <= w_dec_v;
            r_alu_src   <= !w_invalid && !(w_dec[8] || w_dec[3]);
            r_wb        <= !w_invalid && !(w_dec[6] || w_dec[3]);
            r_m         <= !w_invalid && w_dec[8] && (instruction_in[31:25] == 7'b0000001);
            r_inv       <= w_invalid;
        end else if (r_out_valid && !out_ready) begin
            if (w_wr_ok && (reg_file_wr_addr == r_rs1)) r_op1 <= reg_file_wr_data;
            if (w_wr_ok && (reg_file_wr_addr == r_rs2)) r_op2 <= reg_file_wr_data;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Register file: x0 and out-of-range addresses are never written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) r_rf[k] <= '0;
        end else if (w_wr_ok) begin
            r_rf[reg_file_wr_addr[AW-1:0]] <= reg_file_wr_data;
        end
    end

    assign out_valid           = r_out_valid;
    assign pc_out              = r_pc;
    assign op1                 = r_op1;
    assign op2                 = r_op2;
    assign immediate           = r_imm;
    assign rs1                 = r_rs1;
    assign rs2                 = r_rs2;
    assign rd                  = r_rd;
    assign func3               = r_func3;
    assign func7               = r_func7;
    assign decoded_instruction = r_dec;
    assign alu_src             = r_alu_src;
    assign wb_reg_file         = r_wb;
    assign m_type_inst         = r_m;
    assign invalid_inst        = r_inv;
endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: a 32-bit/32-register and a 64-bit/16-register instance, each
// compared every cycle against a reference decode/pipeline model, with directed and random stimulus.
module tb_id_pipe_stage;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [63:0] pc, op1, op2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [8:0]  dec;
        logic        alu_src, wb, m, inv;
    } obs_t;

    typedef struct packed {
        logic        rst, flush, in_valid, out_ready, wr_en;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [4:0]  wr_addr;
        logic [63:0] wr_data;
    } drv_t;

    logic        clk = 1'b0;
    drv_t        drv [2];
    obs_t        obs0, obs1;
    obs_t        m_out [2];
    logic [63:0] m_rf [2][32];
    int          n_compared = 0;
    int          n_mismatched = 0;

    logic        d0_in_ready, d0_out_valid, d0_alu, d0_wb, d0_m, d0_inv;
    logic [31:0] d0_pc, d0_op1, d0_op2, d0_imm;
    logic [4:0]  d0_rs1, d0_rs2, d0_rd;
    logic [2:0]  d0_f3;
    logic [6:0]  d0_f7;
    logic [8:0]  d0_dec;
    logic        d1_in_ready, d1_out_valid, d1_alu, d1_wb, d1_m, d1_inv;
    logic [63:0] d1_pc, d1_op1, d1_op2, d1_imm;
    logic [4:0]  d1_rs1, d1_rs2, d1_rd;
    logic [2:0]  d1_f3;
    logic [6:0]  d1_f7;
    logic [8:0]  d1_dec;

    always #5 clk = ~clk;

    id_pipe_stage #(.XLEN(32), .NUM_REGS(32)) u_dut0 (
        .clk(clk), .rst(drv[0].rst), .id_flush(drv[0].flush),
        .in_valid(drv[0].in_valid), .in_ready(d0_in_ready),
        .instruction_in(drv[0].instr), .pc_in(drv[0].pc[31:0]),
        .reg_file_wr_en(drv[0].wr_en), .reg_file_wr_addr(drv[0].wr_addr),
        .reg_file_wr_data(drv[0].wr_data[31:0]),
        .out_valid(d0_out_valid), .out_ready(drv[0].out_ready),
        .pc_out(d0_pc), .op1(d0_op1), .op2(d0_op2), .immediate(d0_imm),
        .rs1(d0_rs1), .rs2(d0_rs2), .rd(d0_rd), .func3(d0_f3), .func7(d0_f7),
        .decoded_instruction(d0_dec), .alu_src(d0_alu), .wb_reg_file(d0_wb),
        .m_type_inst(d0_m), .invalid_inst(d0_inv)
    );

    id_pipe_stage #(.XLEN(64), .NUM_REGS(16)) u_dut1 (
        .clk(clk), .rst(drv[1].rst), .id_flush(drv[1].flush),
        .in_valid(drv[1].in_valid), .in_ready(d1_in_ready),
        .instruction_in(drv[1].instr), .pc_in(drv[1].pc),
        .reg_file_wr_en(drv[1].wr_en), .reg_file_wr_addr(drv[1].wr_addr),
        .reg_file_wr_data(drv[1].wr_data),
        .out_valid(d1_out_valid), .out_ready(drv[1].out_ready),
        .pc_out(d1_pc), .op1(d1_op1), .op2(d1_op2), .immediate(d1_imm),
        .rs1(d1_rs1), .rs2(d1_rs2), .rd(d1_rd), .func3(d1_f3), .func7(d1_f7),
        .decoded_instruction(d1_dec), .alu_src(d1_alu), .wb_reg_file(d1_wb),
        .m_type_inst(d1_m), .invalid_inst(d1_inv)
    );

    always_comb begin
        obs0 = '{valid: d0_out_valid, pc: {32'b0, d0_pc}, op1: {32'b0, d0_op1}, op2: {32'b0, d0_op2},
                 imm: {32'b0, d0_imm}, rs1: d0_rs1, rs2: d0_rs2, rd: d0_rd, f3: d0_f3, f7: d0_f7,
                 dec: d0_dec, alu_src: d0_alu, wb: d0_wb, m: d0_m, inv: d0_inv};
        obs1 = '{valid: d1_out_valid, pc: d1_pc, op1: d1_op1, op2: d1_op2, imm: d1_imm,
                 rs1: d1_rs1, rs2: d1_rs2, rd: d1_rd, f3: d1_f3, f7: d1_f7,
                 dec: d1_dec, alu_src: d1_alu, wb: d1_wb, m: d1_m, inv: d1_inv};
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode from the ISA encoding tables: classes, used fields, immediates by arithmetic.
    function automatic obs_t model_decode(input logic [31:0] ins, input int nregs, input logic [63:0] mk);
        obs_t        o;
        longint      s;
        logic [63:0] im;
        bit          ok, ur1, ur2, urd;
        logic [6:0]  opc;
        o = '0; im = 64'd0; ok = 1'b1; ur1 = 1'b0; ur2 = 1'b0; urd = 1'b0;
        opc = ins[6:0];
        o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.rd = ins[11:7];
        o.f3 = ins[14:12]; o.f7 = ins[31:25];
        s = longint'($signed(ins));
        case (opc)
            7'h33: begin o.dec = 9'h100; ur1 = 1'b1; ur2 = 1'b1; urd = 1'b1; end
            7'h13: begin o.dec = 9'h080; ur1 = 1'b1; urd = 1'b1; im = 64'(s >>> 20); end
            7'h23: begin o.dec = 9'h040; ur1 = 1'b1; ur2 = 1'b1;
                         im = 64'((s >>> 25) * 32) | (64'(s >> 7) & 64'd31); end
            7'h03: begin o.dec = 9'h020; ur1 = 1'b1; urd = 1'b1; im = 64'(s >>> 20); end
            7'h37: begin o.dec = 9'h010; urd = 1'b1; im = 64'(s) & ~64'hFFF; end
            7'h63: begin o.dec = 9'h008; ur1 = 1'b1; ur2 = 1'b1;
                         im = 64'((s >>> 31) * 4096) + (64'(ins[7]) * 2048) +
                              (64'(ins[30:25]) * 32) + (64'(ins[11:8]) * 2); end
            7'h6F: begin o.dec = 9'h004; urd = 1'b1;
                         im = 64'((s >>> 31) * 1048576) + (64'(ins[19:12]) * 4096) +
                              (64'(ins[20]) * 2048) + (64'(ins[30:21]) * 2); end
            7'h17: begin o.dec = 9'h002; urd = 1'b1; im = 64'(s) & ~64'hFFF; end
            7'h67: begin o.dec = 9'h001; ur1 = 1'b1; urd = 1'b1; im = 64'(s >>> 20); end
            default: ok = 1'b0;
        endcase
        if (ur1 && int'(ins[19:15]) >= nregs) ok = 1'b0;
        if (ur2 && int'(ins[24:20]) >= nregs) ok = 1'b0;
        if (urd && int'(ins[11:7]) >= nregs) ok = 1'b0;
        if (!ok) begin o.dec = 9'h000; im = 64'd0; end
        o.imm     = im & mk;
        o.inv     = !ok;
        o.alu_src = ok && (opc != 7'h33) && (opc != 7'h63);
        o.wb      = ok && (opc != 7'h23) && (opc != 7'h63);
        o.m       = ok && (opc == 7'h33) && (ins[31:25] == 7'd1);
        return o;
    endfunction

    task automatic compare_all(input int d);
        obs_t  g, e;
        string p;
        g = (d == 0) ? obs0 : obs1;
        e = m_out[d];
        p = $sformatf("dut%0d", d);
        check_eq({p, " out_valid"}, 64'(g.valid), 64'(e.valid));
        check_eq({p, " pc_out"}, g.pc, e.pc);
        check_eq({p, " op1"}, g.op1, e.op1);
        check_eq({p, " op2"}, g.op2, e.op2);
        check_eq({p, " immediate"}, g.imm, e.imm);
        check_eq({p, " rs1/rs2/rd"}, 64'({g.rs1, g.rs2, g.rd}), 64'({e.rs1, e.rs2, e.rd}));
        check_eq({p, " func3/func7"}, 64'({g.f3, g.f7}), 64'({e.f3, e.f7}));
        check_eq({p, " decoded"}, 64'(g.dec), 64'(e.dec));
        check_eq({p, " alu/wb/m/inv"}, 64'({g.alu_src, g.wb, g.m, g.inv}),
                 64'({e.alu_src, e.wb, e.m, e.inv}));
    endtask

    // One clock: check in_ready, advance the model with the current inputs, check registered outputs.
    task automatic step();
        obs_t nxt [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int          nr;
            logic [63:0] mk, wd;
            bit          wr_ok, rdy, acc;
            nr    = (d == 0) ? 32 : 16;
            mk    = (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
            wd    = drv[d].wr_data & mk;
            wr_ok = drv[d].wr_en && (drv[d].wr_addr != 5'd0) && (int'(drv[d].wr_addr) < nr);
            rdy   = !m_out[d].valid || drv[d].out_ready;
            acc   = drv[d].in_valid && rdy;
            check_eq($sformatf("dut%0d in_ready", d), 64'((d == 0) ? d0_in_ready : d1_in_ready), 64'(rdy));
            nxt[d] = m_out[d];
            if (!drv[d].rst) begin
                nxt[d] = '0;
            end else if (drv[d].flush) begin
                nxt[d].valid = 1'b0;
            end else if (acc) begin
                nxt[d]       = model_decode(drv[d].instr, nr, mk);
                nxt[d].valid = 1'b1;
                nxt[d].pc    = drv[d].pc & mk;
                nxt[d].op1   = (BYPASS && wr_ok && drv[d].wr_addr == nxt[d].rs1) ? wd : m_rf[d][nxt[d].rs1];
                nxt[d].op2   = (BYPASS && wr_ok && drv[d].wr_addr == nxt[d].rs2) ? wd : m_rf[d][nxt[d].rs2];
            end else if (m_out[d].valid && !drv[d].out_ready) begin
                if (wr_ok && drv[d].wr_addr == m_out[d].rs1) nxt[d].op1 = wd;
                if (wr_ok && drv[d].wr_addr == m_out[d].rs2) nxt[d].op2 = wd;
            end else begin
                nxt[d].valid = 1'b0;
            end
            if (!drv[d].rst) begin
                for (int k = 0; k < 32; k++) m_rf[d][k] = 64'd0;
            end else if (wr_ok) begin
                m_rf[d][drv[d].wr_addr] = wd;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_out[d] = nxt[d];
            compare_all(d);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd_f, input logic [4:0] a, input logic [4:0] b);
        return {7'b0000000, b, a, 3'b000, rd_f, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd_f, input logic [4:0] a, input logic [11:0] im);
        return {im, a, 3'b000, rd_f, 7'b0010011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opc;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0: opc = 7'b0110011;  1: opc = 7'b0010011;  2: opc = 7'b0100011;
            3: opc = 7'b0000011;  4: opc = 7'b0110111;  5: opc = 7'b1100011;
            6: opc = 7'b1101111;  7: opc = 7'b0010111;  8: opc = 7'b1100111;
            default: opc = ins[6:0];
        endcase
        ins[6:0] = opc;
        if (opc == 7'b0110011 && $urandom_range(0, 1) == 1) ins[31:25] = 7'b0000001;
        if ($urandom_range(0, 1) == 1) begin
            ins[24] = 1'b0; ins[19] = 1'b0; ins[11] = 1'b0;
        end
        return ins;
    endfunction

    task automatic idle(input int d);
        drv[d] = '{rst: 1'b1, flush: 1'b0, in_valid: 1'b0, out_ready: 1'b1, wr_en: 1'b0,
                   instr: 32'd0, pc: 64'd0, wr_addr: 5'd0, wr_data: 64'd0};
    endtask

    task automatic wr(input int d, input logic [4:0] a, input logic [63:0] v);
        drv[d].wr_en = 1'b1; drv[d].wr_addr = a; drv[d].wr_data = v;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_out[d] = '0;
            for (int k = 0; k < 32; k++) m_rf[d][k] = 64'd0;
            idle(d);
            drv[d].rst = 1'b0;
        end
        step();
        step();
        check_eq("reset out_valid", 64'(d0_out_valid), 64'd0);
        for (int d = 0; d < 2; d++) drv[d].rst = 1'b1;
        step();
        check_eq("in_ready after reset", 64'(d0_in_ready), 64'd1);

        // addi x1,x0,5
        drv[0].in_valid = 1'b1; drv[0].instr = 32'h0050_0093; drv[0].pc = 64'h100;
        step();
        check_eq("addi valid", 64'(d0_out_valid), 64'd1);
        check_eq("addi rd", 64'(d0_rd), 64'd1);
        check_eq("addi imm", 64'(d0_imm), 64'd5);
        check_eq("addi dec", 64'(d0_dec), 64'h080);
        check_eq("addi alu_src", 64'(d0_alu), 64'd1);

        // add x4,x2,x3 accepted, then held three cycles with x2 written mid-hold
        drv[0].instr = enc_r(5'd4, 5'd2, 5'd3); drv[0].pc = 64'h104;
        step();
        drv[0].in_valid = 1'b0; drv[0].out_ready = 1'b0;
        step();
        check_eq("hold in_ready", 64'(d0_in_ready), 64'd0);
        drv[0].in_valid = 1'b1; drv[0].instr = enc_i(5'd9, 5'd9, 12'h7FF);
        wr(0, 5'd2, 64'hA5);
        step();
        check_eq("held op1 refresh", 64'(d0_op1), 64'hA5);
        check_eq("held pc", 64'(d0_pc), 64'h104);
        drv[0].wr_en = 1'b0;
        step();

        // add x3,x1,x1 accepted with a same-cycle write of x1
        drv[0].in_valid = 1'b0; drv[0].out_ready = 1'b1;
        wr(0, 5'd1, 64'd3);
        step();
        drv[0].in_valid = 1'b1; drv[0].instr = enc_r(5'd3, 5'd1, 5'd1);
        wr(0, 5'd1, 64'd7);
        step();
        check_eq("bypass op1", 64'(d0_op1), BYPASS ? 64'd7 : 64'd3);
        check_eq("bypass op2", 64'(d0_op2), BYPASS ? 64'd7 : 64'd3);

        // flush with a would-be accept
        drv[0].wr_en = 1'b0; drv[0].flush = 1'b1; drv[0].instr = enc_i(5'd9, 5'd1, 12'h001);
        step();
        check_eq("flush out_valid", 64'(d0_out_valid), 64'd0);
        check_eq("flush rd kept", 64'(d0_rd), 64'd3);
        idle(0);

        // RV-E instance: add x17,x1,x2 is illegal, write to x17 ignored
        wr(1, 5'd1, 64'd11);
        step();
        wr(1, 5'd2, 64'd22);
        step();
        drv[1].wr_en = 1'b0; drv[1].in_valid = 1'b1; drv[1].instr = enc_r(5'd17, 5'd1, 5'd2);
        step();
        check_eq("rve invalid", 64'(d1_inv), 64'd1);
        check_eq("rve wb", 64'(d1_wb), 64'd0);
        drv[1].in_valid = 1'b0;
        wr(1, 5'd17, 64'hDEAD);
        step();
        drv[1].wr_en = 1'b0; drv[1].in_valid = 1'b1; drv[1].instr = enc_r(5'd5, 5'd1, 5'd2);
        step();
        check_eq("rve x1 intact", d1_op1, 64'd11);

        // lui x5,0x80000 on XLEN=64, then reset during a hold
        drv[1].instr = 32'h8000_02B7;
        step();
        check_eq("lui64 imm", d1_imm, 64'hFFFF_FFFF_8000_0000);
        drv[1].in_valid = 1'b0;
        wr(1, 5'd5, 64'h1234);
        step();
        drv[1].wr_en = 1'b0; drv[1].in_valid = 1'b1; drv[1].instr = enc_i(5'd6, 5'd5, 12'h000);
        step();
        drv[1].in_valid = 1'b0; drv[1].out_ready = 1'b0;
        step();
        check_eq("held op1 x5", d1_op1, 64'h1234);
        drv[1].rst = 1'b0;
        step();
        check_eq("reset mid-hold valid", 64'(d1_out_valid), 64'd0);
        drv[1].rst = 1'b1; drv[1].out_ready = 1'b1; drv[1].in_valid = 1'b1;
        step();
        check_eq("x5 after reset", d1_op1, 64'd0);

        for (int n = 0; n < 800; n++) begin
            for (int d = 0; d < 2; d++) begin
                drv[d].rst       = ($urandom_range(0, 99) != 0);
                drv[d].flush     = ($urandom_range(0, 15) == 0);
                drv[d].in_valid  = ($urandom_range(0, 9) < 7);
                drv[d].out_ready = ($urandom_range(0, 9) < 6);
                drv[d].wr_en     = ($urandom_range(0, 1) == 1);
                drv[d].wr_addr   = 5'($urandom_range(0, 31));
                drv[d].wr_data   = {$urandom, $urandom};
                drv[d].pc        = {$urandom, $urandom};
                drv[d].instr     = rand_instr();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
